// File: rtl/bob_if.sv
// Branch order buffer port bundle: allocation, resolution, flush, commit and RAS recovery signals.
// The master drives the requests; the buffer (slave) returns tags, status and recovery data.
interface bob_if;
  logic        alloc_vld_i;
  logic [3:0]  alloc_rasptr_i;
  logic [2:0]  alloc_tag_o;
  logic        full_o;
  logic        empty_o;
  logic [3:0]  count_o;
  logic        res_vld_i;
  logic [2:0]  res_tag_i;
  logic        res_mispred_i;
  logic        ext_flush_i;
  logic        commit_vld_o;
  logic        bob_vld_f1r_o;
  logic [3:0]  bob_rasptr_f1r_o;
  logic [15:0] bob_misp_cnt_o;

  modport master (
    output alloc_vld_i, alloc_rasptr_i, res_vld_i, res_tag_i, res_mispred_i, ext_flush_i,
    input  alloc_tag_o, full_o, empty_o, count_o, commit_vld_o,
           bob_vld_f1r_o, bob_rasptr_f1r_o, bob_misp_cnt_o
  );

  modport slave (
    input  alloc_vld_i, alloc_rasptr_i, res_vld_i, res_tag_i, res_mispred_i, ext_flush_i,
    output alloc_tag_o, full_o, empty_o, count_o, commit_vld_o,
           bob_vld_f1r_o, bob_rasptr_f1r_o, bob_misp_cnt_o
  );
endinterface

// File: rtl/bob.sv
// 8-entry branch order buffer checkpointing RAS pointers; commit is same-cycle, RAS recovery one cycle after a mispredict.
// Allocation is refused while full or recovering; BOB_MISP_CNT_EN adds a saturating mispredict counter.
module bob (
  input  logic clock,
  input  logic reset_n,
  bob_if.slave bus
);

  typedef enum logic {IDLE, RECOVER} state_t;

  state_t     state;
  logic [3:0] head;
  logic [3:0] tail;
  logic [7:0] valid;
  logic [7:0] resolved;
  logic [3:0] rasptr [8];
  logic [3:0] rec_ptr;

  logic [2:0] head_idx;
  logic [2:0] tail_idx;
  logic [2:0] tag_dist;
  logic [3:0] rec_tail;
  logic       full;
  logic       res_hit;
  logic       mispred_hit;
  logic       commit;
  logic       alloc;

  assign head_idx = head[2:0];
  assign tail_idx = tail[2:0];
  assign full     = ((head_idx == tail_idx) && (head[3] != tail[3])) || (state == RECOVER);

  assign res_hit     = bus.res_vld_i & valid[bus.res_tag_i];
  assign mispred_hit = res_hit & bus.res_mispred_i;
  assign commit      = valid[head_idx] & resolved[head_idx] & ~bus.ext_flush_i;
  assign alloc       = bus.alloc_vld_i & ~full & ~mispred_hit & ~bus.ext_flush_i;

  // Age of the mispredicted entry relative to head; the new tail sits just past it.
  assign tag_dist = bus.res_tag_i - head_idx;
  assign rec_tail = head + {1'b0, tag_dist} + 4'd1;

  assign bus.full_o           = full;
  assign bus.empty_o          = (head == tail);
  assign bus.count_o          = tail - head;
  assign bus.alloc_tag_o      = tail_idx;
  assign bus.commit_vld_o     = commit;
  assign bus.bob_vld_f1r_o    = (state == RECOVER);
  assign bus.bob_rasptr_f1r_o = rec_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      valid    <= '0;
      resolved <= '0;
      rec_ptr  <= '0;
      for (int i = 0; i < 8; i++) rasptr[i] <= '0;
    end else if (bus.ext_flush_i) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      valid    <= '0;
      resolved <= '0;
      rec_ptr  <= '0;
    end else begin
      if (commit) begin
        valid[head_idx] <= 1'b0;
        head            <= head + 4'd1;
      end
      if (res_hit) resolved[bus.res_tag_i] <= 1'b1;
      if (alloc) begin
        valid[tail_idx]    <= 1'b1;
        resolved[tail_idx] <= 1'b0;
        rasptr[tail_idx]   <= bus.alloc_rasptr_i;
        tail               <= tail + 4'd1;
      end
      if (mispred_hit) begin
        // Head is never younger than the tag, so this cannot collide with the commit clear.
        for (int i = 0; i < 8; i++) begin
          if ((3'(i) - head_idx) > tag_dist) valid[i] <= 1'b0;
        end
        tail    <= rec_tail;
        state   <= RECOVER;
        rec_ptr <= rasptr[bus.res_tag_i];
      end else begin
        state   <= IDLE;
        rec_ptr <= '0;
      end
    end
  end

`ifdef BOB_MISP_CNT_EN
  logic [15:0] misp_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      misp_cnt <= '0;
    end else if (mispred_hit && !bus.ext_flush_i && (misp_cnt != 16'hFFFF)) begin
      misp_cnt <= misp_cnt + 16'd1;
    end
  end

  assign bus.bob_misp_cnt_o = misp_cnt;
`else
  assign bus.bob_misp_cnt_o = '0;
`endif

endmodule
